// File: rtl/i2c_txn_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_txn_arbiter
//
// Shares one byte-level I2C transaction engine between two requesters:
//   requester 0 - HDMI transmitter config sequencer
//   requester 1 - runtime register-write port from the host bus
// Round-robin grant, automatic retry on NACK, per-attempt watchdog and
// per-requester completion status. The engine's END/ACK status lines come
// from the engine's slow clock domain and are synchronised here.
//
// Ports:
//   iCLK               system clock, rising edge
//   iRST               synchronous active-high reset
//   reqN_valid         requester N has a transaction pending (held to ready)
//   reqN_data[23:0]    {slave, sub, data}, stable while reqN_valid
//   reqN_ready         one-cycle pulse: request accepted, data captured
//   reqN_done          one-cycle pulse: transaction finished
//   reqN_err[1:0]      with reqN_done: 0 ok, 1 NACK after retries, 2 timeout
//   eng_go             level request to the engine
//   eng_data[23:0]     transaction word to the engine, stable while eng_go
//   eng_end            engine done/idle level (engine clock domain)
//   eng_ack            engine status, high = NACK (valid while eng_end high)
//   busy               high whenever the arbiter is not idle
// ----------------------------------------------------------------------------
module i2c_txn_arbiter #(
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT_CYC = 1048576,
    parameter logic [7:0]  SLAVE_MASK  = 8'hFE
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        req0_valid,
    input  logic [23:0] req0_data,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [1:0]  req0_err,
    input  logic        req1_valid,
    input  logic [23:0] req1_data,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [1:0]  req1_err,
    output logic        eng_go,
    output logic [23:0] eng_data,
    input  logic        eng_end,
    input  logic        eng_ack,
    output logic        busy
);

    localparam logic [3:0]  MAX_R   = 4'(MAX_RETRY);
    localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        EVAL   = 3'd3,
        GAP    = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state;
    logic        lastGrant;
    logic        grantee;
    logic [3:0]  retryCnt;
    logic [20:0] toCnt;
    logic        gapCnt;
    logic        ackLat;

    logic endMeta, endSync;
    logic ackMeta, ackSync;

    // Force the R/W bit of the slave byte to write.
    function automatic logic [23:0] maskSlave(input logic [23:0] word);
        return {word[23:16] & SLAVE_MASK, word[15:0]};
    endfunction

    // Retry counter saturates rather than wrapping.
    function automatic logic [3:0] satInc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // ---- Stage: engine status synchroniser (2 flops, not reset so they
    // always track the engine, including right after reset) ----
    always_ff @(posedge iCLK) begin
        endMeta <= eng_end;
        endSync <= endMeta;
        ackMeta <= eng_ack;
        ackSync <= ackMeta;
    end

    // ---- Stage: arbitration / transaction FSM with registered outputs ----
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            lastGrant  <= 1'b1;
            grantee    <= 1'b0;
            retryCnt   <= 4'd0;
            toCnt      <= 21'd0;
            gapCnt     <= 1'b0;
            ackLat     <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 2'd0;
            req1_err   <= 2'd0;
            eng_go     <= 1'b0;
            eng_data   <= 24'd0;
            busy       <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 2'd0;
            req1_err   <= 2'd0;

            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        // Requester 1 wins when alone or when 0 was served last.
                        if (req1_valid && (!req0_valid || !lastGrant)) begin
                            req1_ready <= 1'b1;
                            eng_data   <= maskSlave(req1_data);
                            lastGrant  <= 1'b1;
                            grantee    <= 1'b1;
                        end else begin
                            req0_ready <= 1'b1;
                            eng_data   <= maskSlave(req0_data);
                            lastGrant  <= 1'b0;
                            grantee    <= 1'b0;
                        end
                        retryCnt <= 4'd0;
                        toCnt    <= 21'd0;
                        eng_go   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end

                LAUNCH, RUN: begin
                    if (toCnt >= TO_LAST) begin
                        // Watchdog expired: abort without retry.
                        eng_go <= 1'b0;
                        state  <= RESP;
                        if (grantee) begin
                            req1_done <= 1'b1;
                            req1_err  <= 2'd2;
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= 2'd2;
                        end
                    end else begin
                        toCnt <= toCnt + 21'd1;
                        // LAUNCH waits for the engine to leave idle so a stale
                        // END from the previous transfer is not taken as done.
                        if (state == LAUNCH && !endSync) begin
                            state <= RUN;
                        end else if (state == RUN && endSync) begin
                            ackLat <= ackSync;
                            eng_go <= 1'b0;
                            state  <= EVAL;
                        end
                    end
                end

                EVAL: begin
                    if (!ackLat) begin
                        state <= RESP;
                        if (grantee) req1_done <= 1'b1;
                        else         req0_done <= 1'b1;
                    end else if (retryCnt < MAX_R) begin
                        retryCnt <= satInc4(retryCnt);
                        gapCnt   <= 1'b0;
                        state    <= GAP;
                    end else begin
                        state <= RESP;
                        if (grantee) begin
                            req1_done <= 1'b1;
                            req1_err  <= 2'd1;
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= 2'd1;
                        end
                    end
                end

                GAP: begin
                    // Two consecutive END-high cycles guarantee the engine has
                    // seen GO low before the next attempt.
                    if (endSync) begin
                        if (gapCnt) begin
                            toCnt  <= 21'd0;
                            eng_go <= 1'b1;
                            state  <= LAUNCH;
                        end else begin
                            gapCnt <= 1'b1;
                        end
                    end else begin
                        gapCnt <= 1'b0;
                    end
                end

                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    eng_go <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
module tb_i2c_txn_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        req0_valid = 1'b0;
    logic [23:0] req0_data = 24'd0;
    logic        req0_ready, req0_done;
    logic [1:0]  req0_err;
    logic        req1_valid = 1'b0;
    logic [23:0] req1_data = 24'd0;
    logic        req1_ready, req1_done;
    logic [1:0]  req1_err;
    logic        eng_go;
    logic [23:0] eng_data;
    logic        eng_end = 1'b1;
    logic        eng_ack = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 iCLK = ~iCLK;

    i2c_txn_arbiter #(
        .MAX_RETRY  (3),
        .TIMEOUT_CYC(1000),
        .SLAVE_MASK (8'hFE)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req0_done (req0_done),
        .req0_err  (req0_err),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .req1_done (req1_done),
        .req1_err  (req1_err),
        .eng_go    (eng_go),
        .eng_data  (eng_data),
        .eng_end   (eng_end),
        .eng_ack   (eng_ack),
        .busy      (busy)
    );

    // Behavioural engine: starts on a GO rising edge, drops END after a short
    // start delay, then finishes per the next plan entry (0 ack, 1 nack,
    // 2 hang until GO is withdrawn).
    int engBusyLen = 20;
    int planQ[$];
    int engPhase = 0;
    int engCnt = 0;
    int engBeh = 0;
    logic prevGoE = 1'b0;

    always @(negedge iCLK) begin
        case (engPhase)
            0: if (eng_go && !prevGoE) begin
                   engBeh = (planQ.size() > 0) ? planQ.pop_front() : 0;
                   engPhase = 1;
                   engCnt = 3;
               end
            1: begin
                   engCnt--;
                   if (engCnt == 0) begin
                       eng_end = 1'b0;
                       engPhase = 2;
                       engCnt = engBusyLen;
                   end
               end
            2: if (engBeh == 2) begin
                   if (!eng_go) begin
                       engPhase = 3;
                       engCnt = 5;
                   end
               end else begin
                   engCnt--;
                   if (engCnt == 0) begin
                       eng_end = 1'b1;
                       eng_ack = (engBeh == 1);
                       engPhase = 0;
                   end
               end
            3: begin
                   engCnt--;
                   if (engCnt == 0) begin
                       eng_end = 1'b1;
                       eng_ack = 1'b0;
                       engPhase = 0;
                   end
               end
            default: engPhase = 0;
        endcase
        prevGoE = eng_go;
    end

    // Observers of whole-run properties, tallied for the tasks to compare.
    int goRises = 0, goViol = 0, dataViol = 0, done0Cnt = 0, done1Cnt = 0;
    logic prevGoM = 1'b0;
    logic [23:0] prevData = 24'd0;

    always @(negedge iCLK) begin
        if (eng_go && !prevGoM) goRises++;
        if (eng_go && !busy) goViol++;
        if (eng_go && prevGoM && eng_data != prevData) dataViol++;
        if (req0_done) done0Cnt++;
        if (req1_done) done1Cnt++;
        prevGoM = eng_go;
        prevData = eng_data;
    end

    // Reference: round-robin pointer as the specification defines it.
    int modelLast = 1;

    function automatic logic [23:0] expWord(input logic [23:0] d);
        logic [7:0] s;
        s = d[23:16] & 8'hFE;
        return {s, d[15:0]};
    endfunction

    task automatic wait_ready(input int budget, output int who, output bit ok);
        ok = 1'b0;
        who = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge iCLK); #1;
            if (req0_ready || req1_ready) begin
                who = (req0_ready && req1_ready) ? 3 : (req0_ready ? 0 : 1);
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int who, input int budget, output logic [1:0] err, output bit ok);
        ok = 1'b0;
        err = 2'd3;
        for (int i = 0; i < budget; i++) begin
            @(posedge iCLK); #1;
            if (who == 0 && req0_done) begin err = req0_err; ok = 1'b1; break; end
            if (who == 1 && req1_done) begin err = req1_err; ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        checks++;
        if ({req0_ready, req1_ready, req0_done, req1_done} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", {req0_ready, req1_ready, req0_done, req1_done});
        end
        checks++;
        if ({req0_err, req1_err} !== 4'b0) begin
            errors++; $display("FAIL reset_err: got %b want 0000", {req0_err, req1_err});
        end
        checks++;
        if (eng_go !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_go_busy: go=%b busy=%b want 0 0", eng_go, busy);
        end
        checks++;
        if (eng_data !== 24'd0) begin
            errors++; $display("FAIL reset_eng_data: got %h want 000000", eng_data);
        end
        iRST = 1'b0;
        modelLast = 1;
        repeat (3) @(posedge iCLK);
        #1;
    endtask

    task automatic test_arbitration();
        int who; bit ok; logic [1:0] e;
        int expSeq[3] = '{0, 1, 0};
        engBusyLen = 10;
        req0_data = 24'h101112; req1_data = 24'h202122;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready(50, who, ok);
            checks++;
            if (!ok || who != expSeq[k]) begin
                errors++; $display("FAIL arb_grant%0d: got %0d want %0d", k, who, expSeq[k]);
            end
            if (who == 0) req0_valid = 1'b0; else if (who == 1) req1_valid = 1'b0;
            wait_done((who == 1) ? 1 : 0, 500, e, ok);
            checks++;
            if (!ok || e !== 2'd0) begin
                errors++; $display("FAIL arb_done%0d: ok=%0d err=%0d want ok=1 err=0", k, ok, e);
            end
            modelLast = who;
            // Re-present the served requester alongside the waiting one.
            if (k == 0) req0_valid = 1'b1;
            if (k == 1) req1_valid = 1'b1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        // Leftover req1 may have been re-granted; let any transfer drain.
        wait_ready(3, who, ok);
        if (ok) begin
            checks++;
            errors++; $display("FAIL arb_extra_grant: got grant %0d want none", who);
        end
        repeat (5) @(posedge iCLK); #1;
    endtask

    task automatic test_single();
        bit ok; logic [1:0] e; int base;
        engBusyLen = 500;
        base = goRises;
        repeat (2) @(posedge iCLK); #1;
        req0_data = 24'h729803; req0_valid = 1'b1;
        @(posedge iCLK); #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL single_latency: ready0=%b ready1=%b want 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        checks++;
        if (eng_data !== 24'h729803 || eng_go !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL single_launch: data=%h go=%b busy=%b want 729803 1 1", eng_data, eng_go, busy);
        end
        modelLast = 0;
        wait_done(0, 2000, e, ok);
        checks++;
        if (!ok || e !== 2'd0) begin
            errors++; $display("FAIL single_done: ok=%0d err=%0d want 1 0", ok, e);
        end
        checks++;
        if (goRises - base != 1) begin
            errors++; $display("FAIL single_attempts: got %0d want 1", goRises - base);
        end
        checks++;
        if (goViol != 0 || dataViol != 0) begin
            errors++; $display("FAIL single_go_window: goViol=%0d dataViol=%0d want 0 0", goViol, dataViol);
        end
        repeat (3) @(posedge iCLK); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_mask();
        int who; bit ok; logic [1:0] e;
        engBusyLen = 15;
        req1_data = 24'h731055; req1_valid = 1'b1;
        wait_ready(10, who, ok);
        req1_valid = 1'b0;
        checks++;
        if (!ok || who != 1 || eng_data !== 24'h721055) begin
            errors++; $display("FAIL mask_slave: who=%0d data=%h want 1 721055", who, eng_data);
        end
        modelLast = 1;
        wait_done(1, 500, e, ok);
        checks++;
        if (!ok || e !== 2'd0) begin
            errors++; $display("FAIL mask_done: ok=%0d err=%0d want 1 0", ok, e);
        end
        repeat (5) @(posedge iCLK); #1;
    endtask

    task automatic test_nack_all();
        int who; bit ok; logic [1:0] e; int base;
        engBusyLen = 12;
        repeat (4) planQ.push_back(1);
        base = goRises;
        req1_data = 24'h44AA55; req1_valid = 1'b1;
        wait_ready(10, who, ok);
        req1_valid = 1'b0;
        modelLast = 1;
        wait_done(1, 2000, e, ok);
        checks++;
        if (!ok || e !== 2'd1) begin
            errors++; $display("FAIL nack_all_err: ok=%0d err=%0d want 1 1", ok, e);
        end
        checks++;
        if (goRises - base != 4) begin
            errors++; $display("FAIL nack_all_attempts: got %0d want 4", goRises - base);
        end
        planQ.delete();
        repeat (5) @(posedge iCLK); #1;
    endtask

    task automatic test_nack_nack_ack();
        int who; bit ok; logic [1:0] e; int base;
        engBusyLen = 12;
        planQ.push_back(1); planQ.push_back(1); planQ.push_back(0);
        base = goRises;
        req0_data = 24'h3C0102; req0_valid = 1'b1;
        wait_ready(10, who, ok);
        req0_valid = 1'b0;
        modelLast = 0;
        wait_done(0, 2000, e, ok);
        checks++;
        if (!ok || e !== 2'd0) begin
            errors++; $display("FAIL nna_err: ok=%0d err=%0d want 1 0", ok, e);
        end
        checks++;
        if (goRises - base != 3) begin
            errors++; $display("FAIL nna_attempts: got %0d want 3", goRises - base);
        end
        planQ.delete();
        repeat (5) @(posedge iCLK); #1;
    endtask

    task automatic test_timeout();
        int who; bit ok; logic [1:0] e; int n; int base;
        planQ.push_back(2);
        base = goRises;
        req0_data = 24'h5A0000; req0_valid = 1'b1;
        wait_ready(10, who, ok);
        req0_valid = 1'b0;
        modelLast = 0;
        n = 0;
        while (eng_go === 1'b1 && n < 3000) begin
            @(posedge iCLK); #1;
            n++;
        end
        checks++;
        if (n != 1000) begin
            errors++; $display("FAIL timeout_cycles: go dropped after %0d want 1000", n);
        end
        checks++;
        if (req0_done !== 1'b1 || req0_err !== 2'd2) begin
            errors++; $display("FAIL timeout_err: done=%b err=%0d want 1 2", req0_done, req0_err);
        end
        checks++;
        if (goRises - base != 1) begin
            errors++; $display("FAIL timeout_no_retry: attempts %0d want 1", goRises - base);
        end
        repeat (20) @(posedge iCLK); #1;
        engBusyLen = 10;
        req1_data = 24'h600708; req1_valid = 1'b1;
        wait_ready(10, who, ok);
        req1_valid = 1'b0;
        modelLast = 1;
        wait_done(1, 2000, e, ok);
        checks++;
        if (!ok || e !== 2'd0) begin
            errors++; $display("FAIL timeout_recover: ok=%0d err=%0d want 1 0", ok, e);
        end
        planQ.delete();
        repeat (5) @(posedge iCLK); #1;
    endtask

    task automatic test_reset_mid();
        int who; bit ok; logic [1:0] e; int d0, d1, n;
        engBusyLen = 300;
        req0_data = 24'h7E0F0F; req0_valid = 1'b1;
        wait_ready(10, who, ok);
        req0_valid = 1'b0;
        repeat (60) @(posedge iCLK); #1;
        checks++;
        if (eng_go !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_running: go=%b busy=%b want 1 1", eng_go, busy);
        end
        d0 = done0Cnt; d1 = done1Cnt;
        iRST = 1'b1;
        @(posedge iCLK); #1;
        checks++;
        if (eng_go !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop: go=%b busy=%b want 0 0", eng_go, busy);
        end
        repeat (4) @(posedge iCLK); #1;
        iRST = 1'b0;
        modelLast = 1;
        n = 0;
        while (engPhase != 0 && n < 1000) begin
            @(posedge iCLK); #1;
            n++;
        end
        repeat (5) @(posedge iCLK); #1;
        checks++;
        if (done0Cnt != d0 || done1Cnt != d1 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_done: done0 +%0d done1 +%0d busy=%b want 0 0 0", done0Cnt - d0, done1Cnt - d1, busy);
        end
        engBusyLen = 10;
        req0_data = 24'h7E0F0F; req1_data = 24'h121314;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_ready(10, who, ok);
        checks++;
        if (!ok || who != 0) begin
            errors++; $display("FAIL rstmid_first_grant: got %0d want 0", who);
        end
        if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        wait_done((who == 1) ? 1 : 0, 1000, e, ok);
        wait_ready(20, who, ok);
        if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (!ok || who != 1) begin
            errors++; $display("FAIL rstmid_second_grant: got %0d want 1", who);
        end
        wait_done((who == 0) ? 0 : 1, 1000, e, ok);
        modelLast = 1;
        repeat (5) @(posedge iCLK); #1;
    endtask

    task automatic test_random();
        int who; bit ok; logic [1:0] e;
        int mask, order[2], nTx, base;
        int k[2];
        logic [23:0] d[2];
        for (int r = 0; r < 25; r++) begin
            mask = $urandom_range(1, 3);
            d[0] = 24'($urandom); d[1] = 24'($urandom);
            k[0] = $urandom_range(0, 4); k[1] = $urandom_range(0, 4);
            engBusyLen = $urandom_range(5, 30);
            if (mask == 1) begin order[0] = 0; nTx = 1; end
            else if (mask == 2) begin order[0] = 1; nTx = 1; end
            else begin
                order[0] = (modelLast == 0) ? 1 : 0;
                order[1] = 1 - order[0];
                nTx = 2;
            end
            for (int t = 0; t < nTx; t++) begin
                for (int a = 0; a < k[order[t]] && a < 4; a++) planQ.push_back(1);
                if (k[order[t]] < 4) planQ.push_back(0);
            end
            req0_data = d[0]; req1_data = d[1];
            req0_valid = mask[0]; req1_valid = mask[1];
            for (int t = 0; t < nTx; t++) begin
                base = goRises;
                wait_ready(20, who, ok);
                if (who == 0) req0_valid = 1'b0; else if (who == 1) req1_valid = 1'b0;
                checks++;
                if (!ok || who != order[t]) begin
                    errors++; $display("FAIL rand%0d_grant%0d: got %0d want %0d", r, t, who, order[t]);
                end
                checks++;
                if (eng_data !== expWord(d[order[t]])) begin
                    errors++; $display("FAIL rand%0d_data%0d: got %h want %h", r, t, eng_data, expWord(d[order[t]]));
                end
                modelLast = order[t];
                wait_done(order[t], 2000, e, ok);
                checks++;
                if (!ok || e !== ((k[order[t]] < 4) ? 2'd0 : 2'd1)) begin
                    errors++; $display("FAIL rand%0d_err%0d: ok=%0d err=%0d want %0d", r, t, ok, e, (k[order[t]] < 4) ? 0 : 1);
                end
                checks++;
                if (goRises - base != ((k[order[t]] < 4) ? k[order[t]] + 1 : 4)) begin
                    errors++; $display("FAIL rand%0d_attempts%0d: got %0d want %0d", r, t, goRises - base, (k[order[t]] < 4) ? k[order[t]] + 1 : 4);
                end
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
            planQ.delete();
            repeat ($urandom_range(3, 8)) @(posedge iCLK);
            #1;
        end
        checks++;
        if (goViol != 0 || dataViol != 0) begin
            errors++; $display("FAIL final_go_window: goViol=%0d dataViol=%0d want 0 0", goViol, dataViol);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single();
        test_mask();
        test_nack_all();
        test_nack_nack_ack();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares the single byte-level I2C transaction engine (24-bit {slave, sub-address, data} write, GO/END/ACK handshake) between two requesters.
- Requester 0 is the HDMI transmitter config sequencer. Requester 1 is the runtime register-write port driven from the host bus.
- Performs round-robin arbitration, automatic retry on NACK, a watchdog timeout on a hung engine, and per-requester completion status.
- Sits between the requesters and the engine, in the iCLK domain. The engine's slow-clock status outputs are synchronised inside this block.

Parameters:
- MAX_RETRY, 3, extra attempts after a NACK before reporting an error (0..15).
- TIMEOUT_CYC, 1048576, iCLK cycles allowed per attempt, from GO to END, before abort (fits 21 bits).
- SLAVE_MASK, 8'hFE, mask applied to the slave byte; forces bit 0 (R/W) to write.

Ports:
- iCLK  in  1  system clock; all logic on the rising edge.
- iRST  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a transaction pending; held until req0_ready.
- req0_data  in  24  {slave, sub, data}; stable while req0_valid.
- req0_ready  out  1  one-cycle pulse: request accepted and data captured.
- req0_done  out  1  one-cycle pulse: transaction finished.
- req0_err  out  2  valid with req0_done: 0 ok, 1 NACK after all retries, 2 timeout.
- req1_valid, req1_data, req1_ready, req1_done, req1_err: identical to the requester 0 set.
- eng_go  out  1  level request to the engine.
- eng_data  out  24  transaction word to the engine; stable while eng_go.
- eng_end  in  1  engine done/idle level, engine clock domain.
- eng_ack  in  1  engine ack status; high = NACK received; valid when eng_end is high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=1 (requester 0 wins first), retry and timeout counters 0.
- eng_end and eng_ack each pass through a 2-flop synchroniser: end_s, ack_s. Only the synchronised values are used.
- States:
  - IDLE:
    - Only req1_valid set -> grant 1.
    - Only req0_valid set -> grant 0.
    - Both set -> grant the requester that is not last_grant.
    - On grant: in the same cycle pulse reqN_ready, capture data with the slave byte ANDed with SLAVE_MASK, set last_grant=N, retry=0, go to LAUNCH.
    - Grant latency is 1 cycle from valid in IDLE to ready.
  - LAUNCH: eng_go=1, clear timeout counter. Stay until end_s=0 (engine started), then go to RUN.
  - RUN: eng_go=1. When end_s=1, capture ack_s, drop eng_go, go to EVAL.
  - EVAL:
    - ack_s=0 -> RESP with err=0.
    - ack_s=1 and retry<MAX_RETRY -> retry+1, go to GAP.
    - ack_s=1 and retry=MAX_RETRY -> RESP with err=1.
  - GAP: eng_go=0. Wait until end_s=1 held for 2 consecutive cycles, so the engine sees GO low, then go to LAUNCH.
  - RESP: one-cycle reqN_done pulse with reqN_err, then IDLE.
- Timeout:
  - The counter runs in LAUNCH and RUN.
  - When it reaches TIMEOUT_CYC-1: drop eng_go, go to RESP with err=2. No retry on timeout.
- eng_go is never high outside LAUNCH/RUN.
- eng_data changes only in IDLE on a grant.
- The non-granted requester's valid is ignored until the block returns to IDLE. No preemption.
- A requester may assert valid in the same cycle its done pulses. It is arbitrated on the next IDLE cycle.
- Reset mid-transaction: eng_go drops on the next edge, no done pulse is emitted, and the pending request is lost. The requester must re-present it.
- The retry counter is 4 bits and saturates; it is compared against MAX_RETRY only.
- After an err=2 abort, the first LAUNCH of the next transaction still waits for end_s=0. The engine is not reset by this block.

Test Plan:
- req0 only, data 24'h729803, engine ACKs after 500 cycles -> req0_ready 1 cycle after valid; eng_data=24'h729803; req0_done with err=0; eng_go high only during LAUNCH/RUN.
- req0 and req1 valid in the same cycle after reset, then again -> first grant to 0, second to 1, third to 0 (strict alternation).
- Slave byte 8'h73 -> eng_data[23:16]=8'h72.
- Engine NACKs every attempt, MAX_RETRY=3 -> exactly 4 eng_go assertions, each separated by GAP; then req1_done with err=1.
- NACK, NACK, then ACK -> 3 attempts; done with err=0.
- Engine never raises eng_end after starting, TIMEOUT_CYC=1000 -> eng_go drops 1000 cycles after LAUNCH entry; done with err=2; next request is serviced normally.
- iRST asserted during RUN -> eng_go=0 and busy=0 on the next edge; no done pulse; after release, req0 wins a simultaneous request.
